lfp_mult_pipe: RTL
==================

Name: lfp_mult_pipe

Overview:
- Parametrised, pipelined, multi-lane log-domain floating-point (LFP) multiplier.
- Successor to the single-lane combinational E3M4 multiplier.
- Accepts LANES operand pairs per beat with valid/ready handshake; two register stages; optional exponent re-bias with flush-to-zero.
- Sits between the LSTM weight/activation operand fetch and the gate accumulation path.

Parameters:
- EW, 3, exponent width of input operands.
- MW, 4, mantissa width of inputs and outputs (MW >= 2).
- LANES, 4, independent multiplies per beat.
- BIAS, 0, constant subtracted from the output exponent (0 = raw exponent sum, E3M4-compatible).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_a  in  LANES*(1+EW+MW)  operand A per lane, lane i at [i*(1+EW+MW) +: 1+EW+MW], fields {s, e, m}.
- in_b  in  LANES*(1+EW+MW)  operand B, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_y  out  LANES*(2+EW+MW)  product per lane, fields {s, e[EW:0], m[MW-1:0]}.
- out_zero  out  LANES  per-lane flag, product flushed to zero.

Behaviour:
- Correction function c(x) on an MW-bit value:
  - c = 0 if x[MW-1:1] == 0, or if x is all ones.
  - c = 1 otherwise.
  - For MW=4 this is the E3M4 Eq. 3.3 complement.
- Stage 1 (S1), per lane, registered:
  - sum = {e_a,m_a} + {e_b,m_b} + c(m_a) + c(m_b), computed at EW+MW+1 bits with no truncation.
  - s = s_a ^ s_b.
  - z = (e_a == 0) | (e_b == 0).
- Stage 2 (S2), per lane, registered:
  - m_out = sum[MW-1:0] - c(sum[MW-1:0]). No borrow is possible because c=1 implies the value is >= 2.
  - e_raw = sum[EW+MW:MW].
  - If BIAS > 0: e_out = e_raw - BIAS; if e_raw <= BIAS, set z = 1.
  - If z: lane output = all zeros and out_zero[i] = 1. Otherwise lane output = {s, e_out, m_out} and out_zero[i] = 0.
- Pipeline control:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv (combinational from out_ready).
  - S1 loads on in_valid & in_ready.
  - S2 loads from S1 when s1_v & s2_adv.
  - A valid bit clears when its stage advances with no incoming beat.
- Latency 2 cycles; full throughput of 1 beat/cycle while out_ready stays high.
- Stall: with out_ready low, S2 holds out_y, out_zero and out_valid stable. S1 accepts one more beat, then in_ready drops. No beat is lost or duplicated.
- Simultaneous events: S2 drain and S1 refill in the same cycle is allowed; back-to-back beats have no bubble.
- Reset (async, any time including mid-stall):
  - s1_v = s2_v = 0; out_valid = 0; out_y = 0; out_zero = 0.
  - in_ready = 1 after reset, since it follows the cleared stage-valid bits.
  - In-flight beats are discarded.
- Data registers hold when their stage does not load; lanes are fully independent.

Test Plan:
- E3M4, lane 0: a=0_011_0100, b=0_010_1000, out_ready=1 -> 2 cycles later lane0 y=9'h05D, out_zero[0]=0. Same with a sign=1 -> 9'h15D.
- Corrections zero: a=b=0_001_0000 -> y=9'h020. Zero operand a=0_000_1010, b=0_101_0011 -> y=0, out_zero=1.
- BIAS=3 instance: first vector -> y=0_0010_1101 (9'h02D). Vector with e_a=e_b=1, m=0 (e_raw=2 <= 3) -> flushed, out_zero=1.
- Backpressure:
  - Stream beats 1..6; hold out_ready low cycles 3-6 -> out_y constant while stalled, in_ready low after S1 fills.
  - All 6 results emerge in order, none lost or duplicated.
- Full throughput: out_ready=1, in_valid=1 for 16 cycles of random operands -> 16 consecutive out_valid cycles matching a reference model on all LANES lanes.
- Reset: assert rst_n low while S1 and S2 hold data and out_ready=0 -> out_valid=0 and out_y=0 immediately; in_ready=1 after release; no stale beat emitted.

Source files
------------

// File: rtl/lfp_mult_pipe_if.sv
// Beat-level handshake bundle for the pipelined multi-lane LFP multiplier.
// The driver uses the master modport and the multiplier uses the slave modport.
interface lfp_mult_pipe_if #(
    parameter int unsigned EW    = 3,
    parameter int unsigned MW    = 4,
    parameter int unsigned LANES = 4
);
    localparam int unsigned OW = 1 + EW + MW;
    localparam int unsigned YW = 2 + EW + MW;

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*OW-1:0]   in_a;
    logic [LANES*OW-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*YW-1:0]   out_y;
    logic [LANES-1:0]      out_zero;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_zero
    );
endinterface

// File: rtl/lfp_mult_pipe.sv
// Two-stage, multi-lane log-domain FP multiplier with valid/ready flow control.
// S1 adds corrected {e,m} codes; S2 removes the output correction, re-biases and flushes.
module lfp_mult_pipe #(
    parameter int unsigned EW    = 3,
    parameter int unsigned MW    = 4,
    parameter int unsigned LANES = 4,
    parameter int unsigned BIAS  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    lfp_mult_pipe_if.slave lfp_if
);
    localparam int unsigned OW  = 1 + EW + MW;
    localparam int unsigned YW  = 2 + EW + MW;
    localparam int unsigned EMW = EW + MW;
    localparam int unsigned SW  = EW + MW + 1;
    localparam logic [EW:0] BIAS_E = (EW+1)'(BIAS);

    // Mantissa correction: zero for codes 0/1 and for all-ones, one otherwise.
    function automatic logic corr(input logic [MW-1:0] x);
        return (x[MW-1:1] != '0) && !(&x);
    endfunction

    logic                      s1_v_q, s1_v_d;
    logic [LANES-1:0][SW-1:0]  s1_sum_q, s1_sum_d;
    logic [LANES-1:0]          s1_s_q, s1_s_d;
    logic [LANES-1:0]          s1_z_q, s1_z_d;
    logic                      s2_v_q, s2_v_d;
    logic [LANES*YW-1:0]       y_q, y_d;
    logic [LANES-1:0]          zero_q, zero_d;

    logic s2_adv_c, s1_adv_c, in_fire_c, s2_load_c;

    always_comb begin
        s2_adv_c  = ~s2_v_q | lfp_if.out_ready;
        s1_adv_c  = ~s1_v_q | s2_adv_c;
        in_fire_c = lfp_if.in_valid & s1_adv_c;
        s2_load_c = s1_v_q & s2_adv_c;
        s1_v_d    = s1_adv_c ? lfp_if.in_valid : s1_v_q;
        s2_v_d    = s2_adv_c ? s1_v_q : s2_v_q;
    end

    // Stage 1: corrected code sum, sign and zero-operand detect per lane.
    always_comb begin
        logic [OW-1:0] a_l;
        logic [OW-1:0] b_l;
        s1_sum_d = s1_sum_q;
        s1_s_d   = s1_s_q;
        s1_z_d   = s1_z_q;
        a_l      = '0;
        b_l      = '0;
        if (in_fire_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                a_l = lfp_if.in_a[i*OW +: OW];
                b_l = lfp_if.in_b[i*OW +: OW];
                s1_sum_d[i] = SW'(a_l[EMW-1:0]) + SW'(b_l[EMW-1:0])
                            + SW'(corr(a_l[MW-1:0])) + SW'(corr(b_l[MW-1:0]));
                s1_s_d[i]   = a_l[OW-1] ^ b_l[OW-1];
                s1_z_d[i]   = (a_l[EMW-1:MW] == '0) | (b_l[EMW-1:MW] == '0);
            end
        end
    end

    // Stage 2: undo output correction, optional re-bias with flush-to-zero.
    always_comb begin
        logic [MW-1:0] m_raw;
        logic [MW-1:0] m_out;
        logic [EW:0]   e_raw;
        logic [EW:0]   e_out;
        logic          z;
        y_d    = y_q;
        zero_d = zero_q;
        m_raw  = '0;
        m_out  = '0;
        e_raw  = '0;
        e_out  = '0;
        z      = 1'b0;
        if (s2_load_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                m_raw = s1_sum_q[i][MW-1:0];
                m_out = m_raw - MW'(corr(m_raw));
                e_raw = s1_sum_q[i][SW-1:MW];
                e_out = e_raw;
                z     = s1_z_q[i];
                if (BIAS > 0) begin
                    e_out = e_raw - BIAS_E;
                    if (e_raw <= BIAS_E) z = 1'b1;
                end
                y_d[i*YW +: YW] = z ? '0 : {s1_s_q[i], e_out, m_out};
                zero_d[i]       = z;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_sum_q <= '0;
            s1_s_q   <= '0;
            s1_z_q   <= '0;
            s2_v_q   <= 1'b0;
            y_q      <= '0;
            zero_q   <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_sum_q <= s1_sum_d;
            s1_s_q   <= s1_s_d;
            s1_z_q   <= s1_z_d;
            s2_v_q   <= s2_v_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
        end
    end

    assign lfp_if.in_ready  = s1_adv_c;
    assign lfp_if.out_valid = s2_v_q;
    assign lfp_if.out_y     = y_q;
    assign lfp_if.out_zero  = zero_q;
endmodule
